spart_rx: RTL

Serial receive stage of the SPART. It samples the asynchronous `rxd` line using the 16x oversample tick from the baud generator, deframes 8N1 characters, and buffers them. It presents the oldest byte and `rda` to the bus interface, which pops one byte per `read_en` strobe. It also reports sticky framing and overrun errors.

---
 rtl/spart_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spart_rx.sv
// SPART receive stage: 2-flop rxd synchronizer, 8N1 deframer, receive buffer, sticky error flags.
// Define SPART_RX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register.
module spart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       baud_en,
  input  logic       read_en,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [3:0] SC_MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SC_END = 4'(OVERSAMPLE - 1);

  state_e     state_q, state_d;
  logic       sync1_q, rxs_q, rxs_prev_q;
  logic [3:0] sc_q, sc_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] sh_q, sh_d;
  logic       fe_q, fe_d, ov_q, ov_d;
  logic       push, fe_set, ov_set, pop;

  // Deframer: start qualified at bit centre, data and stop sampled at the end of each bit count.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bc_d    = bc_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = START;
          sc_d    = 4'd0;
          bc_d    = 3'd0;
        end
      end
      START: begin
        if (baud_en) begin
          if (sc_q == SC_MID) begin
            state_d = rxs_q ? IDLE : DATA;
            sc_d    = 4'd0;
            bc_d    = 3'd0;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (baud_en) begin
          if (sc_q == SC_END) begin
            sh_d = {rxs_q, sh_q[7:1]};
            sc_d = 4'd0;
            bc_d = bc_q + 3'd1;
            if (bc_q == 3'd7) begin
              state_d = STOP;
              bc_d    = 3'd0;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (baud_en) begin
          if (sc_q == SC_END) begin
            push    = rxs_q;
            fe_set  = !rxs_q;
            state_d = IDLE;
            sc_d    = 4'd0;
            bc_d    = 3'd0;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPART_RX_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, mem_we;

  // Circular buffer; a pop in the same cycle frees the slot for a push into a full buffer.
  always_comb begin
    full     = (cnt_q == CW'(FIFO_DEPTH));
    empty    = (cnt_q == CW'(0));
    pop      = read_en && !empty;
    mem_we   = push && (!full || pop);
    ov_set   = push && full && !pop;
    wr_ptr_d = mem_we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(mem_we) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (mem_we) mem_q[wr_ptr_q] <= sh_q;
    end
  end

  assign rx_data = mem_q[rd_ptr_q];
  assign rda     = !empty;
`else
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d;
  logic       accept;

  // FIFO_DEPTH has no effect in the single-register build.
  if (FIFO_DEPTH == 0) begin : g_fifo_depth_ignored
  end

  // Single holding register; the first byte is kept when a second one arrives unread.
  always_comb begin
    pop     = read_en && valid_q;
    accept  = push && (!valid_q || pop);
    ov_set  = push && valid_q && !pop;
    hold_d  = accept ? sh_q : hold_q;
    valid_d = accept || (valid_q && !pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign rx_data = hold_q;
  assign rda     = valid_q;
`endif

  // Sticky flags: any read_en clears them, a coincident set event wins.
  always_comb begin
    fe_d = fe_set || (fe_q && !read_en);
    ov_d = ov_set || (ov_q && !read_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      sc_q       <= 4'd0;
      bc_q       <= 3'd0;
      sh_q       <= 8'h00;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      sc_q       <= sc_d;
      bc_q       <= bc_d;
      sh_q       <= sh_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  assign framing_err = fe_q;
  assign overrun     = ov_q;

endmodule
